spi_slave_monitor_core: RTL

//  Parametrised, synthesisable capture engine for the slave monitor BFM. It passively

---
 rtl/spi_slave_monitor_core_if.sv | 15 +
 rtl/spi_slave_monitor_core.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_monitor_core_if.sv
// Valid/ready capture handshake between the SPI slave monitor core and its proxy.
// The core drives the word side through the master modport; the proxy only returns ready.
interface spi_slave_monitor_core_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CS_IDX_W   = 1
);
  logic                  mon_valid;
  logic                  mon_ready;
  logic [DATA_WIDTH-1:0] mon_mosi_data;
  logic [DATA_WIDTH-1:0] mon_miso_data;
  logic [CS_IDX_W-1:0]   mon_cs_index;

  modport master (output mon_valid, mon_mosi_data, mon_miso_data, mon_cs_index, input mon_ready);
  modport slave  (input mon_valid, mon_mosi_data, mon_miso_data, mon_cs_index, output mon_ready);
endinterface

// File: rtl/spi_slave_monitor_core.sv
// Passive SPI capture engine: oversamples SCLK/CS_n/MOSI/MISO on pclk, decodes any CPOL/CPHA
// mode, queues MOSI/MISO word pairs per selected slave and flags protocol errors.
module spi_slave_monitor_core #(
  parameter int DATA_WIDTH   = 8,
  parameter int NO_OF_SLAVES = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    pclk,
  input  logic                    areset,
  input  logic                    cpol,
  input  logic                    cpha,
  input  logic                    lsb_first,
  input  logic                    sclk,
  input  logic [NO_OF_SLAVES-1:0] cs_n,
  input  logic                    mosi,
  input  logic                    miso,
  spi_slave_monitor_core_if.master mon,
  output logic                    overflow_err,
  output logic                    cs_conflict,
  output logic                    abort_pulse
);
  localparam int CS_IDX_W = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1;
  localparam int CS_CNT_W = $clog2(NO_OF_SLAVES + 1);
  localparam int CNT_W    = $clog2(DATA_WIDTH);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int EW       = CS_IDX_W + 2 * DATA_WIDTH;
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
  localparam logic [AW:0]      DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACTIVE = 2'd1, ST_CONFLICT = 2'd2} state_e;

  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] cur,
                                                     input logic b, input logic lsb);
    logic [DATA_WIDTH-1:0] r;
    if (lsb) r = {b, cur[DATA_WIDTH-1:1]};
    else     r = {cur[DATA_WIDTH-2:0], b};
    return r;
  endfunction

  logic [2:0]              sclk_sync_q, sclk_sync_d;
  logic [1:0]              mosi_sync_q, mosi_sync_d, miso_sync_q, miso_sync_d;
  logic [NO_OF_SLAVES-1:0] cs_s1_q, cs_s1_d, cs_s2_q, cs_s2_d;
  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   mosi_sh_q, mosi_sh_d, miso_sh_q, miso_sh_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [CS_IDX_W-1:0]     idx_q, idx_d, sel_idx_s;
  logic [CS_CNT_W-1:0]     low_cnt_s;
  logic [NO_OF_SLAVES-1:0] cs_low_s, sel_mask_s;
  logic                    sel_high_s, others_low_s, sample_s, push_s, abort_s, conflict_set_s;
  logic [EW-1:0]           mem_q [FIFO_DEPTH];
  logic [EW-1:0]           mem_d [FIFO_DEPTH];
  logic [AW:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_s;
  logic                    full_s, pop_s, wr_en_s;
  logic [EW-1:0]           push_word_s, head_q, head_d;
  logic                    valid_q, valid_d, overflow_q, overflow_d;
  logic                    conflict_q, conflict_d, abort_q, abort_d;

  // Synchronisers; SCLK is XORed with cpol so its idle level is always 0 and the chain resets to 0.
  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], sclk ^ cpol};
    mosi_sync_d = {mosi_sync_q[0], mosi};
    miso_sync_d = {miso_sync_q[0], miso};
    cs_s1_d     = cs_n;
    cs_s2_d     = cs_s1_q;
  end

  // Edge selection and chip-select decode from the synchronised pins.
  always_comb begin
    if (cpha) sample_s = ~sclk_sync_q[1] &  sclk_sync_q[2];
    else      sample_s =  sclk_sync_q[1] & ~sclk_sync_q[2];
    cs_low_s  = ~cs_s2_q;
    low_cnt_s = '0;
    sel_idx_s = '0;
    for (int i = 0; i < NO_OF_SLAVES; i++) begin
      low_cnt_s     = low_cnt_s + CS_CNT_W'(cs_low_s[i]);
      sel_mask_s[i] = (idx_q == CS_IDX_W'(i));
      if (cs_low_s[i]) sel_idx_s = CS_IDX_W'(i);
      else             sel_idx_s = sel_idx_s;
    end
    others_low_s = |(cs_low_s & ~sel_mask_s);
    sel_high_s   = ~|(cs_low_s & sel_mask_s);
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (low_cnt_s > CS_CNT_W'(1'b1))       state_d = ST_CONFLICT;
        else if (low_cnt_s == CS_CNT_W'(1'b1)) state_d = ST_ACTIVE;
        else                                   state_d = ST_IDLE;
      end
      ST_ACTIVE: begin
        if (sel_high_s)        state_d = ST_IDLE;
        else if (others_low_s) state_d = ST_CONFLICT;
        else                   state_d = ST_ACTIVE;
      end
      ST_CONFLICT: begin
        if (low_cnt_s == '0) state_d = ST_IDLE;
        else                 state_d = ST_CONFLICT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: shifting, word completion and error detection; an edge beats a same-cycle CS release.
  always_comb begin
    mosi_sh_d      = mosi_sh_q;
    miso_sh_d      = miso_sh_q;
    bit_cnt_d      = bit_cnt_q;
    idx_d          = idx_q;
    push_s         = 1'b0;
    abort_s        = 1'b0;
    conflict_set_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (low_cnt_s > CS_CNT_W'(1'b1)) begin
          conflict_set_s = 1'b1;
        end else if (low_cnt_s == CS_CNT_W'(1'b1)) begin
          idx_d     = sel_idx_s;
          bit_cnt_d = '0;
          mosi_sh_d = '0;
          miso_sh_d = '0;
        end else begin
          idx_d = idx_q;
        end
      end
      ST_ACTIVE: begin
        if (sample_s) begin
          mosi_sh_d = shift_in(mosi_sh_q, mosi_sync_q[1], lsb_first);
          miso_sh_d = shift_in(miso_sh_q, miso_sync_q[1], lsb_first);
          if (bit_cnt_q == LAST_BIT) begin
            push_s    = 1'b1;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1'b1);
          end
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
        if (sel_high_s)        abort_s        = (bit_cnt_d != '0);
        else if (others_low_s) conflict_set_s = 1'b1;
        else                   abort_s        = 1'b0;
      end
      ST_CONFLICT: bit_cnt_d = '0;
      default:     bit_cnt_d = '0;
    endcase
  end

  // Capture FIFO; the head is registered and forwarded from the write port when the slot just written becomes head.
  always_comb begin
    count_s     = wr_ptr_q - rd_ptr_q;
    full_s      = (count_s == DEPTH_CNT);
    pop_s       = valid_q & mon.mon_ready;
    wr_en_s     = push_s & (~full_s | pop_s);
    push_word_s = {idx_q, miso_sh_d, mosi_sh_d};
    wr_ptr_d    = wr_ptr_q + (AW+1)'(wr_en_s);
    rd_ptr_d    = rd_ptr_q + (AW+1)'(pop_s);
    mem_d       = mem_q;
    if (wr_en_s) mem_d[wr_ptr_q[AW-1:0]] = push_word_s;
    else         mem_d = mem_q;
    if (wr_en_s && (rd_ptr_d[AW-1:0] == wr_ptr_q[AW-1:0])) head_d = push_word_s;
    else                                                   head_d = mem_q[rd_ptr_d[AW-1:0]];
    valid_d    = (wr_ptr_d != rd_ptr_d);
    overflow_d = overflow_q | (push_s & full_s & ~pop_s);
    conflict_d = conflict_q | conflict_set_s;
    abort_d    = abort_s;
  end

  // State register for synchronisers, FSM, datapath and FIFO.
  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      miso_sync_q <= '0;
      cs_s1_q     <= '1;
      cs_s2_q     <= '1;
      state_q     <= ST_IDLE;
      mosi_sh_q   <= '0;
      miso_sh_q   <= '0;
      bit_cnt_q   <= '0;
      idx_q       <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      head_q      <= '0;
      valid_q     <= 1'b0;
      overflow_q  <= 1'b0;
      conflict_q  <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      miso_sync_q <= miso_sync_d;
      cs_s1_q     <= cs_s1_d;
      cs_s2_q     <= cs_s2_d;
      state_q     <= state_d;
      mosi_sh_q   <= mosi_sh_d;
      miso_sh_q   <= miso_sh_d;
      bit_cnt_q   <= bit_cnt_d;
      idx_q       <= idx_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      head_q      <= head_d;
      valid_q     <= valid_d;
      overflow_q  <= overflow_d;
      conflict_q  <= conflict_d;
      abort_q     <= abort_d;
    end
  end

  assign mon.mon_valid     = valid_q;
  assign mon.mon_cs_index  = head_q[EW-1 -: CS_IDX_W];
  assign mon.mon_miso_data = head_q[2*DATA_WIDTH-1 -: DATA_WIDTH];
  assign mon.mon_mosi_data = head_q[DATA_WIDTH-1:0];
  assign overflow_err      = overflow_q;
  assign cs_conflict       = conflict_q;
  assign abort_pulse       = abort_q;
endmodule
